// File: rtl/ace_ccu_snoop_resp.sv
// rtl/ace_ccu_snoop_resp.sv - snoop CR response collector and aggregator
//
// Purpose:
//   Control entries from the snoop request path are queued in order. The
//   entry at the head of the queue names which snooped ports must answer
//   (sel) and which initiator gets the merged answer (idx). This block
//   collects one CR response from every selected port and ORs them together.
//   It then presents the merged response to the chosen initiator. Only one
//   transaction is handled at a time, and always the oldest one.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ctrl_valid_i/ready_o     control entry handshake
//   ctrl_i                   control entry (packed struct: sel above idx)
//   cr_valids_i/readies_o    per-snooped-port CR handshake
//   cr_resps_i               per-snooped-port CR resp, port j at [5j+4:5j]
//   cr_valids_o/readies_i    per-initiator aggregated response handshake
//   cr_resp_o                aggregated response, shared by all initiators
module ace_ccu_snoop_resp #(
  parameter int unsigned NumInp    = 0,
  parameter int unsigned NumOup    = 0,
  parameter int unsigned CtrlDepth = 2,
  parameter type         ctrl_t    = logic,
  // Degenerate zero-sized defaults are clamped so the ports stay legal.
  localparam int unsigned InpW = (NumInp > 0) ? NumInp : 1,
  localparam int unsigned OupW = (NumOup > 0) ? NumOup : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ctrl_valid_i,
  output logic              ctrl_ready_o,
  input  ctrl_t             ctrl_i,
  input  logic [OupW-1:0]   cr_valids_i,
  output logic [OupW-1:0]   cr_readies_o,
  input  logic [OupW*5-1:0] cr_resps_i,
  output logic [InpW-1:0]   cr_valids_o,
  input  logic [InpW-1:0]   cr_readies_i,
  output logic [4:0]        cr_resp_o
);

  localparam int unsigned IdxW   = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned DepthW = (CtrlDepth > 0) ? CtrlDepth : 1;
  localparam int unsigned PtrW   = (DepthW > 1) ? $clog2(DepthW) : 1;
  localparam int unsigned CntW   = $clog2(DepthW + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  // Control FIFO
  ctrl_t            fifo_q [DepthW];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fifo_full, fifo_empty, push, pop;

  // Head entry split into fields. The entry is reinterpreted as a flat
  // vector so that the field layout does not depend on the default ctrl_t.
  logic [OupW+IdxW-1:0] head_bits;
  logic [OupW-1:0]      head_sel;
  logic [IdxW-1:0]      head_idx;

  // Transaction state
  logic [1:0]      state_q, state_d;
  logic [OupW-1:0] pending_q, pending_d;
  logic [4:0]      acc_q, acc_d;
  logic [OupW-1:0] cr_hs;
  logic [4:0]      cr_or;
  logic [InpW-1:0] resp_sel;

  assign fifo_full    = (cnt_q == CntW'(DepthW));
  assign fifo_empty   = (cnt_q == '0);
  assign ctrl_ready_o = !fifo_full;
  // No bypass: a full FIFO refuses the push even while the head pops.
  assign push         = ctrl_valid_i && !fifo_full;

  assign head_bits = (OupW + IdxW)'(fifo_q[rd_ptr_q]);
  assign head_sel  = head_bits[IdxW +: OupW];
  assign head_idx  = head_bits[IdxW-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DepthW - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DepthW - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    acc_d        = acc_q;
    pop          = 1'b0;
    cr_hs        = '0;
    cr_or        = '0;
    resp_sel     = '0;
    cr_readies_o = '0;
    cr_valids_o  = '0;
    cr_resp_o    = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pending_d = head_sel;
          acc_d     = '0;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        // Ready depends only on registered state, never on cr_valids_i.
        cr_readies_o = pending_q;
        cr_hs        = cr_valids_i & pending_q;
        for (int unsigned j = 0; j < OupW; j++) begin
          cr_or = cr_or | (cr_resps_i[j*5 +: 5] & {5{cr_hs[j]}});
        end
        acc_d     = acc_q | cr_or;
        pending_d = pending_q & ~cr_hs;
        // Looking at the next pending mask saves a cycle after the last
        // handshake; an empty sel leaves COLLECT after one cycle.
        if (pending_d == '0) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        resp_sel    = InpW'(1) << head_idx;
        cr_valids_o = resp_sel;
        cr_resp_o   = acc_q;
        if ((cr_readies_i & resp_sel) != '0) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= ctrl_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      pending_q <= '0;
      acc_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_ace_ccu_snoop_resp.sv
// tb/tb_ace_ccu_snoop_resp.sv - scoreboard bench for ace_ccu_snoop_resp
module tb_ace_ccu_snoop_resp;

  typedef struct packed {
    logic [2:0] sel;
    logic       idx;
  } ctrl_t;

  typedef struct packed {
    logic       idx;
    logic [4:0] resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_valid;
  logic        ctrl_ready;
  ctrl_t       ctrl;
  logic [2:0]  cr_valids_in;
  logic [2:0]  cr_readies_out;
  logic [14:0] cr_resps_in;
  logic [1:0]  cr_valids_out;
  logic [1:0]  cr_readies_in;
  logic [4:0]  cr_resp_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_resp  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ace_ccu_snoop_resp #(
    .NumInp   (2),
    .NumOup   (3),
    .CtrlDepth(2),
    .ctrl_t   (ctrl_t)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ctrl_valid_i (ctrl_valid),
    .ctrl_ready_o (ctrl_ready),
    .ctrl_i       (ctrl),
    .cr_valids_i  (cr_valids_in),
    .cr_readies_o (cr_readies_out),
    .cr_resps_i   (cr_resps_in),
    .cr_valids_o  (cr_valids_out),
    .cr_readies_i (cr_readies_in),
    .cr_resp_o    (cr_resp_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Scoreboard: every aggregated-response handshake pops one expectation.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] ev;
    if (rst_n && ((cr_valids_out & cr_readies_in) != 2'b00)) begin
      n_resp++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e  = sb.pop_front();
        ev = 2'b01 << e.idx;
        chk("resp_valids", 32'(cr_valids_out), 32'(ev));
        chk("resp_data", 32'(cr_resp_out), 32'(e.resp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    ctrl_valid    = 1'b0;
    ctrl          = '0;
    cr_valids_in  = '0;
    cr_resps_in   = '0;
    cr_readies_in = '0;
    tick();
    tick();
    samp();
    chk("rst_ctrl_ready", 32'(ctrl_ready), 32'd1);
    chk("rst_cr_readies", 32'(cr_readies_out), 32'd0);
    chk("rst_cr_valids", 32'(cr_valids_out), 32'd0);
    chk("rst_cr_resp", 32'(cr_resp_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two ports selected, answering three cycles apart; port1 stays valid.
    ctrl_valid = 1'b1;
    ctrl       = '{sel: 3'b101, idx: 1'b1};
    sb.push_back('{idx: 1'b1, resp: 5'b01001});
    tick();
    ctrl_valid = 1'b0;
    tick();
    cr_valids_in = 3'b011;
    cr_resps_in  = {5'b00000, 5'b11111, 5'b00001};
    samp();
    chk("t1_readies_t0", 32'(cr_readies_out), 32'b101);
    tick();
    cr_valids_in = 3'b010;
    samp();
    chk("t1_readies_t1", 32'(cr_readies_out), 32'b100);
    tick();
    samp();
    chk("t1_readies_t2", 32'(cr_readies_out), 32'b100);
    chk("t1_no_valid_t2", 32'(cr_valids_out), 32'd0);
    tick();
    cr_valids_in = 3'b110;
    cr_resps_in  = {5'b01000, 5'b11111, 5'b00000};
    samp();
    chk("t1_no_valid_t3", 32'(cr_valids_out), 32'd0);
    tick();
    cr_valids_in = 3'b010;
    samp();
    chk("t1_valids_t4", 32'(cr_valids_out), 32'b10);
    chk("t1_resp_t4", 32'(cr_resp_out), 32'b01001);
    chk("t1_readies_t4", 32'(cr_readies_out), 32'd0);
    cr_readies_in = 2'b01;
    tick();
    samp();
    chk("t1_wrong_ready", 32'(cr_valids_out), 32'b10);
    cr_readies_in = 2'b10;
    tick();
    cr_readies_in = 2'b00;
    cr_valids_in  = 3'b000;
    samp();
    chk("t1_after_pop", 32'(cr_valids_out), 32'd0);

    // All three ports answer in the same cycle.
    ctrl_valid = 1'b1;
    ctrl       = '{sel: 3'b111, idx: 1'b0};
    sb.push_back('{idx: 1'b0, resp: 5'b00111});
    tick();
    ctrl_valid = 1'b0;
    tick();
    cr_valids_in = 3'b111;
    cr_resps_in  = {5'b00010, 5'b00001, 5'b00100};
    samp();
    chk("t2_readies", 32'(cr_readies_out), 32'b111);
    tick();
    cr_valids_in = 3'b000;
    samp();
    chk("t2_valids", 32'(cr_valids_out), 32'b01);
    chk("t2_resp", 32'(cr_resp_out), 32'b00111);
    cr_readies_in = 2'b01;
    tick();
    cr_readies_in = 2'b00;

    // Empty select: respond with zero two edges after the push.
    ctrl_valid = 1'b1;
    ctrl       = '{sel: 3'b000, idx: 1'b1};
    sb.push_back('{idx: 1'b1, resp: 5'b00000});
    tick();
    ctrl_valid = 1'b0;
    samp();
    chk("t3_readies_e0", 32'(cr_readies_out), 32'd0);
    tick();
    samp();
    chk("t3_readies_e1", 32'(cr_readies_out), 32'd0);
    chk("t3_valids_e1", 32'(cr_valids_out), 32'd0);
    tick();
    samp();
    chk("t3_valids_e2", 32'(cr_valids_out), 32'b10);
    chk("t3_resp_e2", 32'(cr_resp_out), 32'd0);
    cr_readies_in = 2'b10;
    tick();
    cr_readies_in = 2'b00;

    // Fill the FIFO behind a stalled head, then drain in push order.
    cr_valids_in = 3'b111;
    cr_resps_in  = {5'b01000, 5'b00100, 5'b00010};
    ctrl_valid   = 1'b1;
    ctrl         = '{sel: 3'b001, idx: 1'b0};
    sb.push_back('{idx: 1'b0, resp: 5'b00010});
    tick();
    ctrl = '{sel: 3'b010, idx: 1'b1};
    samp();
    chk("t4_ready_second", 32'(ctrl_ready), 32'd1);
    sb.push_back('{idx: 1'b1, resp: 5'b00100});
    tick();
    ctrl = '{sel: 3'b100, idx: 1'b0};
    samp();
    chk("t4_full", 32'(ctrl_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      samp();
      chk("t4_stall_valids", 32'(cr_valids_out), 32'b01);
      chk("t4_stall_resp", 32'(cr_resp_out), 32'b00010);
      chk("t4_stall_readies", 32'(cr_readies_out), 32'd0);
      chk("t4_stall_full", 32'(ctrl_ready), 32'd0);
      tick();
    end
    cr_readies_in = 2'b11;
    begin
      bit accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
        samp();
        if (ctrl_ready) begin
          accepted = 1'b1;
          sb.push_back('{idx: 1'b0, resp: 5'b01000});
        end
        tick();
      end
      ctrl_valid = 1'b0;
      chk("t4_third_accepted", 32'(accepted), 32'd1);
    end
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      tick();
    end
    chk("t4_drained", 32'(sb.size()), 32'd0);
    cr_readies_in = 2'b00;
    cr_valids_in  = 3'b000;
    tick();

    // Reset while a port is still pending: the entry is dropped silently.
    ctrl_valid = 1'b1;
    ctrl       = '{sel: 3'b011, idx: 1'b1};
    tick();
    ctrl_valid = 1'b0;
    tick();
    cr_valids_in = 3'b001;
    samp();
    chk("t5_readies", 32'(cr_readies_out), 32'b011);
    tick();
    cr_valids_in = 3'b000;
    samp();
    chk("t5_still_pending", 32'(cr_readies_out), 32'b010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl_ready", 32'(ctrl_ready), 32'd1);
    chk("t5_rst_readies", 32'(cr_readies_out), 32'd0);
    chk("t5_rst_valids", 32'(cr_valids_out), 32'd0);
    chk("t5_rst_resp", 32'(cr_resp_out), 32'd0);
    tick();
    tick();
    rst_n         = 1'b1;
    cr_valids_in  = 3'b111;
    cr_readies_in = 2'b11;
    for (int i = 0; i < 10; i++) begin
      samp();
      chk("t5_quiet_readies", 32'(cr_readies_out), 32'd0);
      tick();
    end
    chk("total_responses", 32'(n_resp), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
